// File: rtl/mini_cpu_pkg.sv
// Shared types and instruction-field helpers for the mini CPU core.
// Instruction layout, MSB to LSB: {opcode[2:0], rd, rs1, opf}.
package mini_cpu_pkg;

    typedef enum logic [2:0] {
        OP_LOAD    = 3'd0,
        OP_ADD     = 3'd1,
        OP_ADDI    = 3'd2,
        OP_SUB     = 3'd3,
        OP_SUBI    = 3'd4,
        OP_MUL     = 3'd5,
        OP_CLEAR   = 3'd6,
        OP_DISPLAY = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_FETCH        = 3'd1,
        S_EXEC         = 3'd2,
        S_MUL_ITER     = 3'd3,
        S_WRITE        = 3'd4,
        S_WAIT_RELEASE = 3'd5
    } state_t;

    // Total instruction width.
    function automatic int instr_width(int reg_aw, int opf_w);
        return 3 + 2 * reg_aw + opf_w;
    endfunction

    // LSB position of the rs1 field.
    function automatic int rs1_lsb(int opf_w);
        return opf_w;
    endfunction

    // LSB position of the rd field.
    function automatic int rd_lsb(int reg_aw, int opf_w);
        return opf_w + reg_aw;
    endfunction

    // LSB position of the opcode field.
    function automatic int op_lsb(int reg_aw, int opf_w);
        return opf_w + 2 * reg_aw;
    endfunction

endpackage

// File: rtl/mini_cpu_regfile.sv
// Register file: NUM_REGS x DATA_W, two asynchronous read ports, one
// synchronous write port and a single-cycle synchronous clear of all entries.
module mini_cpu_regfile
    import mini_cpu_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 16,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              i_clk,
    input  logic              i_ligar,
    input  logic              i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_clr,
    input  logic [REG_AW-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [REG_AW-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    // Storage: clear-all takes priority over a write (never both in one cycle).
    always_ff @(posedge i_clk or negedge i_ligar) begin
        if (!i_ligar) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_regs[i_raddr_a];
    assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/mini_cpu_core.sv
// Parametrised button-stepped mini CPU: one instruction per press of enviar.
// Optional saturating arithmetic is enabled by defining MINI_CPU_SAT_EN;
// without it results wrap in two's complement.
// Handshake: a press is a 1->0 edge of the synchronised enviar seen in IDLE;
// the FSM then runs the instruction and waits for release before re-arming.
// r_state is the FSM state register to bind assertions/monitors against.
module mini_cpu_core
    import mini_cpu_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 16,
    parameter  int IMM_W    = 6,
    parameter  int CNT_W    = 16,
    localparam int REG_AW   = $clog2(NUM_REGS),
    localparam int OPF_W    = IMM_W + 1,
    localparam int INSTR_W  = instr_width(REG_AW, OPF_W)
) (
    input  logic               clk,
    input  logic               ligar,
    input  logic [INSTR_W-1:0] instr,
    input  logic               enviar,
    output logic [DATA_W-1:0]  result,
    output logic [DATA_W-1:0]  display_value,
    output logic               flag_z,
    output logic               flag_n,
    output logic               flag_v,
    output logic               busy,
    output logic [CNT_W-1:0]   instr_count
);

    localparam int ITER_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int RS1_L  = rs1_lsb(OPF_W);
    localparam int RD_L   = rd_lsb(REG_AW, OPF_W);
    localparam int OP_L   = op_lsb(REG_AW, OPF_W);
`ifdef MINI_CPU_SAT_EN
    localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
`endif

    state_t r_state, w_next_state;

    logic r_sync1, r_sync2, r_sync_prev;
    logic w_press;

    logic [INSTR_W-1:0]  r_instr;
    opcode_t             w_op;
    logic [REG_AW-1:0]   w_rd, w_rs1, w_rs2;
    logic [OPF_W-1:0]    w_opf;
    logic [DATA_W-1:0]   w_imm, w_mag_ext;

    logic [DATA_W-1:0]   w_rd_a, w_rd_b;
    logic                w_rf_we, w_rf_clr;

    logic [DATA_W-1:0]   w_alu_b, w_sum, w_alu_res;
    logic                w_is_imm, w_is_sub, w_is_arith, w_sum_v, w_alu_v;

    logic [DATA_W-1:0]   r_op_a, r_res, r_mplier;
    logic                r_v;
    logic [2*DATA_W-1:0] r_acc, r_mcand;
    logic [ITER_W-1:0]   r_iter;

    logic [DATA_W-1:0]   w_wr_val;
    logic                w_wr_v;

    logic [DATA_W-1:0]   r_result, r_display;
    logic                r_z, r_n, r_v_flag;
    logic [CNT_W-1:0]    r_count;

    // Instruction field decode from the captured copy only.
    assign w_op      = opcode_t'(r_instr[OP_L +: 3]);
    assign w_rd      = r_instr[RD_L +: REG_AW];
    assign w_rs1     = r_instr[RS1_L +: REG_AW];
    assign w_opf     = r_instr[OPF_W-1:0];
    assign w_rs2     = w_opf[OPF_W-1 -: REG_AW];
    assign w_mag_ext = DATA_W'(w_opf[IMM_W-1:0]);
    assign w_imm     = w_opf[OPF_W-1] ? (-w_mag_ext) : w_mag_ext;

    assign w_press   = r_sync_prev & ~r_sync2;

    mini_cpu_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .i_clk     (clk),
        .i_ligar   (ligar),
        .i_we      (w_rf_we),
        .i_waddr   (w_rd),
        .i_wdata   (w_wr_val),
        .i_clr     (w_rf_clr),
        .i_raddr_a (w_rs1),
        .o_rdata_a (w_rd_a),
        .i_raddr_b (w_rs2),
        .o_rdata_b (w_rd_b)
    );

    // Two-flop synchroniser plus edge-detect history; idle level is released (1).
    always_ff @(posedge clk or negedge ligar) begin
        if (!ligar) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync_prev <= 1'b1;
        end else begin
            r_sync1     <= enviar;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge ligar) begin
        if (!ligar) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:         if (w_press) w_next_state = S_FETCH;
            S_FETCH:        w_next_state = S_EXEC;
            S_EXEC:         w_next_state = (w_op == OP_MUL) ? S_MUL_ITER : S_WRITE;
            S_MUL_ITER:     if (r_iter == ITER_W'(DATA_W - 1)) w_next_state = S_WRITE;
            S_WRITE:        w_next_state = S_WAIT_RELEASE;
            S_WAIT_RELEASE: if (r_sync2) w_next_state = S_IDLE;
            default:        w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs: busy indication and register-file strobes.
    always_comb begin
        busy     = (r_state != S_IDLE);
        w_rf_we  = 1'b0;
        w_rf_clr = 1'b0;
        if (r_state == S_WRITE) begin
            w_rf_clr = (w_op == OP_CLEAR);
            w_rf_we  = (w_op != OP_CLEAR) && (w_op != OP_DISPLAY);
        end
    end

    // ALU for LOAD and add/sub forms; the overflowed result takes a's sign.
    always_comb begin
        w_is_imm   = (w_op == OP_ADDI) || (w_op == OP_SUBI);
        w_is_sub   = (w_op == OP_SUB)  || (w_op == OP_SUBI);
        w_is_arith = (w_op == OP_ADD)  || (w_op == OP_ADDI) || w_is_sub;
        w_alu_b    = w_is_imm ? w_imm : w_rd_b;
        w_sum      = w_is_sub ? (w_rd_a - w_alu_b) : (w_rd_a + w_alu_b);
        if (w_is_sub)
            w_sum_v = (w_rd_a[DATA_W-1] != w_alu_b[DATA_W-1]) &&
                      (w_sum[DATA_W-1] != w_rd_a[DATA_W-1]);
        else
            w_sum_v = (w_rd_a[DATA_W-1] == w_alu_b[DATA_W-1]) &&
                      (w_sum[DATA_W-1] != w_rd_a[DATA_W-1]);
        w_alu_res = w_sum;
        w_alu_v   = 1'b0;
        if (w_op == OP_LOAD) begin
            w_alu_res = w_imm;
        end else if (w_is_arith) begin
            w_alu_v = w_sum_v;
`ifdef MINI_CPU_SAT_EN
            if (w_sum_v) w_alu_res = w_rd_a[DATA_W-1] ? SMIN : SMAX;
`endif
        end
    end

    // Write-back value: multiplier low half or the registered ALU result.
    always_comb begin
        w_wr_val = r_res;
        w_wr_v   = r_v;
        if (w_op == OP_MUL) begin
            w_wr_val = r_acc[DATA_W-1:0];
            w_wr_v   = |r_acc[2*DATA_W-1:DATA_W];
`ifdef MINI_CPU_SAT_EN
            if (w_wr_v) w_wr_val = '1;
`endif
        end
    end

    // Datapath: instruction capture, operand capture, shift-add multiply (LSB first).
    always_ff @(posedge clk or negedge ligar) begin
        if (!ligar) begin
            r_instr  <= '0;
            r_op_a   <= '0;
            r_res    <= '0;
            r_v      <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_iter   <= '0;
        end else begin
            case (r_state)
                S_FETCH: r_instr <= instr;
                S_EXEC: begin
                    r_op_a   <= w_rd_a;
                    r_res    <= w_alu_res;
                    r_v      <= w_alu_v;
                    r_acc    <= '0;
                    r_mcand  <= {{DATA_W{1'b0}}, w_rd_a};
                    r_mplier <= w_rd_b;
                    r_iter   <= '0;
                end
                S_MUL_ITER: begin
                    if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_iter   <= r_iter + ITER_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Architectural outputs, all updated in the single WRITE cycle.
    always_ff @(posedge clk or negedge ligar) begin
        if (!ligar) begin
            r_result  <= '0;
            r_display <= '0;
            r_z       <= 1'b0;
            r_n       <= 1'b0;
            r_v_flag  <= 1'b0;
            r_count   <= '0;
        end else if (r_state == S_WRITE) begin
            r_count <= r_count + CNT_W'(1);
            case (w_op)
                OP_CLEAR:   ;
                OP_DISPLAY: r_display <= r_op_a;
                default: begin
                    r_result <= w_wr_val;
                    r_z      <= (w_wr_val == '0);
                    r_n      <= w_wr_val[DATA_W-1];
                    r_v_flag <= w_wr_v;
                end
            endcase
        end
    end

    assign result        = r_result;
    assign display_value = r_display;
    assign flag_z        = r_z;
    assign flag_n        = r_n;
    assign flag_v        = r_v_flag;
    assign instr_count   = r_count;

endmodule

// File: tb/tb_mini_cpu_core.sv
module tb_mini_cpu_core;
  import mini_cpu_pkg::*;

  localparam int DATA_W  = 16;
  localparam int CNT_W   = 16;
  localparam int INSTR_W = 18;
  localparam int EXP_W   = 16 + 3 + 16 + 16;

  logic               clk;
  logic               ligar;
  logic [INSTR_W-1:0] instr;
  logic               enviar;
  logic [DATA_W-1:0]  result;
  logic [DATA_W-1:0]  display_value;
  logic               flag_z, flag_n, flag_v;
  logic               busy;
  logic [CNT_W-1:0]   instr_count;

  mini_cpu_core #(
    .DATA_W   (16),
    .NUM_REGS (16),
    .IMM_W    (6),
    .CNT_W    (16)
  ) dut (
    .clk           (clk),
    .ligar         (ligar),
    .instr         (instr),
    .enviar        (enviar),
    .result        (result),
    .display_value (display_value),
    .flag_z        (flag_z),
    .flag_n        (flag_n),
    .flag_v        (flag_v),
    .busy          (busy),
    .instr_count   (instr_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [EXP_W-1:0] pack_exp(input logic [15:0] res, input logic z,
                                                input logic n, input logic v,
                                                input logic [15:0] disp, input logic [15:0] cnt);
    return {res, z, n, v, disp, cnt};
  endfunction

  function automatic logic [INSTR_W-1:0] enc(input opcode_t op, input int rd, input int rs1,
                                             input logic [6:0] opf);
    logic [3:0] d, s;
    d = rd[3:0];
    s = rs1[3:0];
    return {op, d, s, opf};
  endfunction

  function automatic logic [6:0] rr(input int rs2);
    return {rs2[3:0], 3'b000};
  endfunction

  function automatic logic [6:0] im(input int sgn, input int mag);
    return {sgn[0], mag[5:0]};
  endfunction

  // ---------------- driver ----------------
  // Press for 'hold' cycles, scramble the switches once the instruction has
  // been captured, wait for busy to drop, then score the popped expectation.
  task automatic run_instr(input string tag, input logic [INSTR_W-1:0] ins, input int hold,
                           input logic [EXP_W-1:0] exp, input int exp_busy);
    int cyc = 0;
    int busy_cnt = 0;
    bit seen = 0;
    bit done = 0;
    logic [EXP_W-1:0] e;
    exp_q.push_back(exp);
    instr = ins;
    @(negedge clk);
    enviar = 1'b0;
    while (!done && cyc < hold + 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == hold) enviar = 1'b1;
      if (busy) begin
        busy_cnt++;
        seen = 1;
        if (busy_cnt == 2) instr = INSTR_W'($urandom);
      end else if (seen) begin
        done = 1;
      end
    end
    enviar = 1'b1;
    check({tag, " completes"}, 32'(done), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, " queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, " result"},  32'(result),        32'(e[50:35]));
      check({tag, " flag_z"},  32'(flag_z),        32'(e[34]));
      check({tag, " flag_n"},  32'(flag_n),        32'(e[33]));
      check({tag, " flag_v"},  32'(flag_v),        32'(e[32]));
      check({tag, " display"}, 32'(display_value), 32'(e[31:16]));
      check({tag, " count"},   32'(instr_count),   32'(e[15:0]));
      if (exp_busy >= 0) check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    end
    repeat (2) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string              name;
    logic [INSTR_W-1:0] ins;
    logic [EXP_W-1:0]   exp;
    int                 busy_cycles;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int cnt;
    ligar  = 1'b0;
    enviar = 1'b1;
    instr  = '0;

    vecs[0]  = '{"load_r1_5",   enc(OP_LOAD, 1, 0, im(0, 5)),   pack_exp(16'h0005, 0, 0, 0, 16'h0000, 16'd1), 4};
    vecs[1]  = '{"load_r2_m3",  enc(OP_LOAD, 2, 0, im(1, 3)),   pack_exp(16'hFFFD, 0, 1, 0, 16'h0000, 16'd2), 4};
    vecs[2]  = '{"add_r3",      enc(OP_ADD, 3, 1, rr(2)),       pack_exp(16'h0002, 0, 0, 0, 16'h0000, 16'd3), 4};
    vecs[3]  = '{"subi_zero",   enc(OP_SUBI, 8, 1, im(0, 5)),   pack_exp(16'h0000, 1, 0, 0, 16'h0000, 16'd4), 4};
    vecs[4]  = '{"display_r1",  enc(OP_DISPLAY, 0, 1, 7'd0),    pack_exp(16'h0000, 1, 0, 0, 16'h0005, 16'd5), 4};
    vecs[5]  = '{"load_r1_63",  enc(OP_LOAD, 1, 0, im(0, 63)),  pack_exp(16'h003F, 0, 0, 0, 16'h0005, 16'd6), 4};
    vecs[6]  = '{"mul_r2",      enc(OP_MUL, 2, 1, rr(1)),       pack_exp(16'h0F81, 0, 0, 0, 16'h0005, 16'd7), 20};
`ifdef MINI_CPU_SAT_EN
    vecs[7]  = '{"mul_ovf",     enc(OP_MUL, 3, 2, rr(2)),       pack_exp(16'hFFFF, 0, 1, 1, 16'h0005, 16'd8), 20};
`else
    vecs[7]  = '{"mul_ovf",     enc(OP_MUL, 3, 2, rr(2)),       pack_exp(16'h5F01, 0, 0, 1, 16'h0005, 16'd8), 20};
`endif
    vecs[8]  = '{"load_r5_8",   enc(OP_LOAD, 5, 0, im(0, 8)),   pack_exp(16'h0008, 0, 0, 0, 16'h0005, 16'd9), 4};
    vecs[9]  = '{"mul_r6",      enc(OP_MUL, 6, 2, rr(5)),       pack_exp(16'h7C08, 0, 0, 0, 16'h0005, 16'd10), 20};
`ifdef MINI_CPU_SAT_EN
    vecs[10] = '{"add_ovf",     enc(OP_ADD, 7, 6, rr(6)),       pack_exp(16'h7FFF, 0, 0, 1, 16'h0005, 16'd11), 4};
`else
    vecs[10] = '{"add_ovf",     enc(OP_ADD, 7, 6, rr(6)),       pack_exp(16'hF810, 0, 1, 1, 16'h0005, 16'd11), 4};
`endif
    vecs[11] = '{"sub_r9",      enc(OP_SUB, 9, 1, rr(5)),       pack_exp(16'h0037, 0, 0, 0, 16'h0005, 16'd12), 4};
`ifdef MINI_CPU_SAT_EN
    vecs[12] = '{"sub_r10",     enc(OP_SUB, 10, 7, rr(6)),      pack_exp(16'h03F7, 0, 0, 0, 16'h0005, 16'd13), 4};
`else
    vecs[12] = '{"sub_r10",     enc(OP_SUB, 10, 7, rr(6)),      pack_exp(16'h7C08, 0, 0, 1, 16'h0005, 16'd13), 4};
`endif
    vecs[13] = '{"subi_neg",    enc(OP_SUBI, 11, 5, im(1, 2)),  pack_exp(16'h000A, 0, 0, 0, 16'h0005, 16'd14), 4};
    vecs[14] = '{"addi_neg_r0", enc(OP_ADDI, 12, 0, im(1, 1)),  pack_exp(16'hFFFF, 0, 1, 0, 16'h0005, 16'd15), 4};
    vecs[15] = '{"load_r0_7",   enc(OP_LOAD, 0, 0, im(0, 7)),   pack_exp(16'h0007, 0, 0, 0, 16'h0005, 16'd16), 4};
    vecs[16] = '{"add_r0_r0",   enc(OP_ADD, 13, 0, rr(0)),      pack_exp(16'h000E, 0, 0, 0, 16'h0005, 16'd17), 4};

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset result",  32'(result),        32'd0);
    check("reset display", 32'(display_value), 32'd0);
    check("reset flags",   32'({flag_z, flag_n, flag_v}), 32'd0);
    check("reset busy",    32'(busy),          32'd0);
    check("reset count",   32'(instr_count),   32'd0);
    ligar = 1'b1;
    repeat (3) @(negedge clk);

    // Table-driven main function.
    for (int i = 0; i < 17; i++)
      run_instr(vecs[i].name, vecs[i].ins, 2, vecs[i].exp, vecs[i].busy_cycles);

    // Held button: exactly one increment of r1 (63 -> 64).
    run_instr("hold_addi", enc(OP_ADDI, 1, 1, im(0, 1)), 100,
              pack_exp(16'h0040, 0, 0, 0, 16'h0005, 16'd18), -1);
    run_instr("display_r1_after_hold", enc(OP_DISPLAY, 0, 1, 7'd0), 2,
              pack_exp(16'h0040, 0, 0, 0, 16'h0040, 16'd19), 4);

    // CLEAR leaves result/flags/display alone, still counts.
    run_instr("clear", enc(OP_CLEAR, 0, 0, 7'd0), 2,
              pack_exp(16'h0040, 0, 0, 0, 16'h0040, 16'd20), 4);
    run_instr("display_r7_cleared", enc(OP_DISPLAY, 0, 7, 7'd0), 2,
              pack_exp(16'h0040, 0, 0, 0, 16'h0000, 16'd21), 4);
    run_instr("add_cleared", enc(OP_ADD, 3, 1, rr(1)), 2,
              pack_exp(16'h0000, 1, 0, 0, 16'h0000, 16'd22), 4);
    run_instr("reload_r1", enc(OP_LOAD, 1, 0, im(0, 63)), 2,
              pack_exp(16'h003F, 0, 0, 0, 16'h0000, 16'd23), 4);

    // Reset in the middle of a multiply.
    begin
      bit seen = 0;
      instr = enc(OP_MUL, 2, 1, rr(1));
      @(negedge clk);
      enviar = 1'b0;
      for (int c = 1; c <= 20 && !seen; c++) begin
        @(negedge clk);
        if (c == 2) enviar = 1'b1;
        if (busy) seen = 1;
      end
      enviar = 1'b1;
      check("midmul busy seen", 32'(seen), 32'd1);
      repeat (7) @(negedge clk);
      check("midmul busy before reset", 32'(busy), 32'd1);
      ligar = 1'b0;
      #1;
      check("midmul reset result",  32'(result),        32'd0);
      check("midmul reset display", 32'(display_value), 32'd0);
      check("midmul reset flags",   32'({flag_z, flag_n, flag_v}), 32'd0);
      check("midmul reset busy",    32'(busy),          32'd0);
      check("midmul reset count",   32'(instr_count),   32'd0);
      repeat (3) @(negedge clk);
      ligar = 1'b1;
      repeat (25) @(negedge clk);
      check("post reset busy",   32'(busy),        32'd0);
      check("post reset result", 32'(result),      32'd0);
      check("post reset count",  32'(instr_count), 32'd0);
    end
    cnt = 1;
    run_instr("after_reset_regs_zero", enc(OP_ADD, 3, 1, rr(1)), 2,
              pack_exp(16'h0000, 1, 0, 0, 16'h0000, 16'(cnt)), 4);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mini_cpu_core.md
Name: mini_cpu_core

Overview:
- Parametrised successor to the 16-bit switch-driven mini CPU.
- Same 8-opcode ISA and one-instruction-per-button-press operation.
- Adds generic width, register count and immediate size, a synchronised button with edge detect, an iterative shift-add multiplier, status flags, a busy indication, a DISPLAY latch and an instruction counter.
- Sits between the board switches/KEYs and the LCD/LED output logic.

Parameters:
- DATA_W, 16: datapath and register width (≥4).
- NUM_REGS, 16: register-file depth, power of 2; REG_AW = clog2(NUM_REGS).
- IMM_W, 6: immediate magnitude bits; operand field OPF_W = IMM_W+1 must be ≥ REG_AW.
- CNT_W, 16: instruction-counter width.

Ports:
- clk  in  1  system clock, all state on posedge
- ligar  in  1  reset, asynchronous, active-low
- instr  in  3+2*REG_AW+OPF_W  {opcode, rd, rs1, opf}; rs2 = opf[OPF_W-1 -: REG_AW]; sign = opf[OPF_W-1]; magnitude = opf[IMM_W-1:0]
- enviar  in  1  execute button, active-low, asynchronous to clk
- result  out  DATA_W  last value written to the register file
- display_value  out  DATA_W  register latched by DISPLAY
- flag_z/flag_n/flag_v  out  1  zero, negative, overflow of last arithmetic write
- busy  out  1  high in every state except IDLE
- instr_count  out  CNT_W  completed instructions, wraps to 0

Behaviour:
- Reset: state=IDLE; all outputs 0; all registers 0; sync flops = 1 (released). Reset asserted at any time, including mid-multiply, aborts the instruction and performs no write.
- Button: enviar passes through a 2-FF synchroniser; a press is a 1→0 transition of the synchronised signal, sampled only in IDLE.
- Immediate: sign-magnitude. imm = sign ? -(zero-extended magnitude) : magnitude, extended to DATA_W.
- Opcodes: LOAD=0 rd=imm; ADD=1 rs1+rs2; ADDI=2 rs1+imm; SUB=3 rs1-rs2; SUBI=4 rs1-imm; MUL=5 low DATA_W bits of unsigned rs1*rs2; CLEAR=6 zero all registers; DISPLAY=7 display_value=rs1.
- FSM transitions:
  - IDLE→FETCH on press.
  - FETCH: instr captured into an internal register; later switch changes are ignored. →EXEC.
  - EXEC: operands read, ALU evaluated. MUL→MUL_ITER; all others→WRITE.
  - MUL_ITER: exactly DATA_W cycles, one multiplier bit per cycle, LSB first, into a 2*DATA_W accumulator. →WRITE.
  - WRITE: one cycle; performs the action below. →WAIT_RELEASE.
  - WAIT_RELEASE: →IDLE on the first cycle the synchronised enviar is 1.
- Latency from the press-detect cycle:
  - Register updated at the end of cycle +3 for non-MUL, +3+DATA_W for MUL.
  - A held button executes exactly once.
- WRITE actions:
  - LOAD/arithmetic: write rd; result=written value; z = (value==0); n = value MSB.
  - v = signed overflow for ADD/ADDI/SUB/SUBI; v = (product upper half ≠ 0) for MUL; v = 0 for LOAD.
  - CLEAR: zeroes all registers in one cycle; result/flags/display/instr_count unchanged.
  - DISPLAY: updates display_value only.
  - Every opcode increments instr_count.
- Any register, including r0, is writable. rd==rs1==rs2 is legal because operands are captured before the write.

Optional Feature:
- Macro: MINI_CPU_SAT_EN.
- Defined: on overflow, ADD/ADDI/SUB/SUBI clamp to 2^(DATA_W-1)-1 or -2^(DATA_W-1), following the sign of the true result. MUL clamps to all-ones. flag_v is still set; z and n follow the clamped value.
- Undefined: two's-complement wrap.

Decomposition:
- mini_cpu_pkg holds:
  - the opcode enum (LOAD..DISPLAY)
  - the state enum (IDLE, FETCH, EXEC, MUL_ITER, WRITE, WAIT_RELEASE)
  - field-offset functions of REG_AW and OPF_W
- Sub-module mini_cpu_regfile: NUM_REGS×DATA_W, 2 asynchronous read ports, 1 synchronous write port, synchronous clear-all, async reset on ligar.
- Multiplier stays inline.

Test Plan (DATA_W=16, NUM_REGS=16, IMM_W=6):
- Sign-magnitude add: LOAD r1,5; LOAD r2 sign=1 mag=3 → r2=0xFFFD. ADD r3,r1,r2 → result=0x0002, z=0, n=0, v=0, instr_count=3.
- Zero flag: SUBI r8,r1,5 (r1=5) → result=0x0000, z=1. Then DISPLAY r1 → display_value=0x0005, result unchanged.
- Multiply overflow:
  - LOAD r1,63; MUL r2,r1,r1 → 0x0F81, v=0, busy high for 20 cycles after press detect.
  - MUL r3,r2,r2 → 0x5F01, v=1; with MINI_CPU_SAT_EN → 0xFFFF.
- Signed add overflow: LOAD r5,8; MUL r6,r2,r5 → 0x7C08. ADD r7,r6,r6 → 0xF810, n=1, v=1; with MINI_CPU_SAT_EN → 0x7FFF, n=0, v=1.
- Button hold and CLEAR:
  - Hold enviar low 100 cycles with ADDI r1,r1,1 → exactly one increment.
  - CLEAR, then DISPLAY r7 → display_value=0; instr_count not reset.
- Reset mid-operation: drop ligar 5 cycles into MUL_ITER → all outputs 0 immediately, registers 0, and after release the state is IDLE with busy=0.
